// File: rtl/multibyte_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// multibyte_add_seq_pkg : shared op encodings and sequencer state type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package multibyte_add_seq_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/multibyte_add_seq_adder8.sv
// ---------------------------------------------------------------------------
// multibyte_add_seq_adder8 : 8-bit ripple-carry adder with carry in/out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multibyte_add_seq_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[8];

endmodule

`default_nettype wire

// File: rtl/multibyte_add_seq.sv
// ---------------------------------------------------------------------------
// multibyte_add_seq : NBYTES-wide add/sub, one byte per clock through adder8
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multibyte_add_seq
  import multibyte_add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  zero,
  output logic                  overflow
);

  localparam int              W        = 8 * NBYTES;
  localparam int              IDXW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] idx;
  logic            c;
  logic            op_q;
  logic [W-1:0]    opa_q;
  logic [W-1:0]    opb_q;

  logic [IDXW+2:0] bit_base;
  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [7:0]      sum;
  logic            cout;
  logic [W-1:0]    result_nxt;
  logic            last;

  assign bit_base = {idx, 3'b000};
  assign a_byte   = opa_q[bit_base +: 8];
  assign b_byte   = (op_q == OP_ADD) ? opb_q[bit_base +: 8] : ~opb_q[bit_base +: 8];
  assign last     = (idx == LAST_IDX);

  multibyte_add_seq_adder8 u_adder8 (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (c),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    result_nxt                = result;
    result_nxt[bit_base +: 8] = sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are captured on the final byte so they are already valid in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      c         <= 1'b0;
      op_q      <= OP_ADD;
      opa_q     <= '0;
      opb_q     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa_q <= opa;
            opb_q <= opb;
            op_q  <= op;
            idx   <= '0;
            c     <= (op == OP_SUB);
          end
        end
        RUN: begin
          result <= result_nxt;
          c      <= cout;
          if (last) begin
            carry_out <= cout;
            zero      <= (result_nxt == '0);
            overflow  <= (a_byte[7] == b_byte[7]) && (sum[7] != a_byte[7]);
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_multibyte_add_seq.sv
// ---------------------------------------------------------------------------
// tb_multibyte_add_seq : self-checking bench for multibyte_add_seq (NBYTES=4)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multibyte_add_seq;
  import multibyte_add_seq_pkg::*;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op    = 1'b0;
  logic [W-1:0] opa   = '0;
  logic [W-1:0] opb   = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  multibyte_add_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         v;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word arithmetic, signed overflow from a widened signed result.
  function automatic vec_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t        v;
    logic [W:0]  u;
    logic [W:0]  s;
    v.op = o;
    v.a  = a;
    v.b  = b;
    if (o == OP_SUB) begin
      v.r = a - b;
      v.c = (a >= b);
      s   = {a[W-1], a} - {b[W-1], b};
    end else begin
      u   = {1'b0, a} + {1'b0, b};
      v.r = u[W-1:0];
      v.c = u[W];
      s   = {a[W-1], a} + {b[W-1], b};
    end
    v.z = (v.r == '0);
    v.v = (s[W] != s[W-1]);
    return v;
  endfunction

  task automatic launch(input vec_t e);
    start = 1'b1;
    op    = e.op;
    opa   = e.a;
    opb   = e.b;
    tick();
    start = 1'b0;
  endtask

  // Entered just after the accepting edge; returns in the done cycle.
  task automatic wait_result(input vec_t e, input bit scramble, input string tag);
    int cyc  = 0;
    int bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      if (scramble) begin
        opa = $urandom;
        opb = $urandom;
        op  = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    check({tag, " latency"},   cyc,       NB);
    check({tag, " busy_cnt"},  bcnt,      NB);
    check({tag, " busy@done"}, busy,      0);
    check({tag, " result"},    result,    e.r);
    check({tag, " carry"},     carry_out, e.c);
    check({tag, " zero"},      zero,      e.z);
    check({tag, " overflow"},  overflow,  e.v);
  endtask

  task automatic do_op(input vec_t e, input string tag);
    launch(e);
    wait_result(e, 1'b0, tag);
    tick();
    check({tag, " done_pulse"}, done, 0);
  endtask

  vec_t tbl[6];
  vec_t e;
  int   seen;

  initial begin
    tbl[0] = '{OP_ADD, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{OP_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{OP_SUB, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 1'b0};

    tick();
    tick();
    check("rst busy",      busy,      0);
    check("rst done",      done,      0);
    check("rst result",    result,    0);
    check("rst carry",     carry_out, 0);
    check("rst zero",      zero,      0);
    check("rst overflow",  overflow,  0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i], $sformatf("vec%0d", i));
    end

    // start held with wandering operands while busy must not disturb the op.
    e = model(OP_ADD, 32'h01020304, 32'h10203040);
    start = 1'b1;
    op    = e.op;
    opa   = e.a;
    opb   = e.b;
    tick();
    wait_result(e, 1'b1, "hold");
    start = 1'b0;
    tick();
    check("hold done_pulse", done, 0);
    check("hold idle", busy, 0);

    // Reset during the second RUN cycle aborts without a done pulse.
    e = model(OP_ADD, 32'h11111111, 32'h22222222);
    launch(e);
    tick();
    rst_n = 1'b0;
    tick();
    check("abort busy",     busy,      0);
    check("abort done",     done,      0);
    check("abort result",   result,    0);
    check("abort carry",    carry_out, 0);
    check("abort zero",     zero,      0);
    check("abort overflow", overflow,  0);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) seen = 1;
    end
    check("abort quiet", seen, 0);
    do_op(model(OP_SUB, 32'hDEADBEEF, 32'h0BADF00D), "restart");

    // Back-to-back with start held: one accept every NB+2 cycles.
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e   = model(1'($urandom_range(0, 1)), $urandom, $urandom);
      op  = e.op;
      opa = e.a;
      opb = e.b;
      if (i == 0) begin
        tick();
      end else begin
        tick();
        check("b2b gap idle", busy, 0);
        tick();
        check("b2b accept", busy, 1);
      end
      wait_result(e, 1'b0, $sformatf("b2b%0d", i));
    end
    start = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h7FFFFFFF;
        1: b = 32'h80000000;
        2: b = a;
        3: a = 32'hFFFFFFFF;
        default: ;
      endcase
      do_op(model(1'($urandom_range(0, 1)), a, b), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
